spi_burst_peripheral: RTL

SPI_BURST_PERIPHERAL -- requirements
Module: spi_burst_peripheral

---
 rtl/spi_burst_pkg.sv | 15 +
 rtl/spi_input_synchronizer.sv | 24 ++
 rtl/spi_burst_peripheral.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/spi_burst_pkg.sv
// Shared types for the burst SPI peripheral: FSM state encoding and bit-counter sizing.
package spi_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDRESS = 2'd1,
    ST_DATA    = 2'd2
  } state_t;

  // Bits needed to count down from n-1 to 0; never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_input_synchronizer.sv
// Two-flop synchronizer for three asynchronous SPI pins; 2-cycle latency, no backpressure.
// Reset value is per bit so an inactive-high select can be forced high.
module spi_input_synchronizer #(
  parameter logic [2:0] RESET_VALUE = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] async_bits,
  output logic [2:0] sync_bits
);

  logic [2:0] meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta      <= RESET_VALUE;
      sync_bits <= RESET_VALUE;
    end else begin
      meta      <= async_bits;
      sync_bits <= meta;
    end
  end

endmodule

// File: rtl/spi_burst_peripheral.sv
// Mode-0 SPI burst peripheral: an address phase, then back-to-back data words, oversampled on clock.
// Pulses appear one cycle after the synchronized SCK edge; read data comes from a one-deep pending register.
module spi_burst_peripheral
  import spi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int AUTO_INCREMENT = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  spi_select_in,
  input  logic                  spi_clock_in,
  input  logic                  spi_data_in,
  output logic                  spi_data_out,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic                  address_out_valid,
  output logic [DATA_WIDTH-1:0] write_data_out,
  output logic                  write_data_out_valid,
  input  logic [DATA_WIDTH-1:0] read_data_in,
  input  logic                  read_data_in_valid,
  output logic                  transaction_active_out,
  output logic                  read_underrun_out
);

  localparam int CW = cnt_width((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH);
  localparam logic [CW-1:0]         ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  logic [2:0]            sync_bits;
  logic                  sel_s, sck_s, mosi_s;
  logic                  sck_prev, sck_rise, sck_fall;
  logic [1:0]            warm;
  logic                  armed;
  state_t                state, next_state;
  logic [CW-1:0]         bit_cnt;
  logic                  start, addr_shift, addr_last, data_shift, word_done;
  logic                  word_start, tx_advance;
  logic                  inc_done;
  logic [DATA_WIDTH-1:0] rx_shift, rx_next;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_empty;
  logic [DATA_WIDTH-1:0] pend_dat;
  logic                  pend_vld;

  spi_input_synchronizer #(
    .RESET_VALUE (3'b100)
  ) u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .async_bits ({spi_select_in, spi_clock_in, spi_data_in}),
    .sync_bits  (sync_bits)
  );

  assign sel_s        = sync_bits[2];
  assign sck_s        = sync_bits[1];
  assign mosi_s       = sync_bits[0];
  assign sck_rise     = sck_s & ~sck_prev;
  assign sck_fall     = ~sck_s & sck_prev;
  assign rx_next      = (rx_shift << 1) | DATA_WIDTH'(mosi_s);
  assign spi_data_out = tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (armed && !sel_s) next_state = ST_ADDRESS;
      ST_ADDRESS: begin
        if (sel_s)                              next_state = ST_IDLE;
        else if (sck_rise && bit_cnt == '0)     next_state = ST_DATA;
      end
      ST_DATA:    if (sel_s) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Mode 0: the master samples on the rise, so a new transmit word is loaded on the
  // first fall of each word (cnt still at DATA_LAST) and shifted on every later fall.
  always_comb begin
    transaction_active_out = (state != ST_IDLE);
    start      = 1'b0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
    word_start = 1'b0;
    tx_advance = 1'b0;
    case (state)
      ST_IDLE:    start = armed && !sel_s;
      ST_ADDRESS: addr_shift = sck_rise;
      ST_DATA: begin
        data_shift = sck_rise;
        word_start = sck_fall && (bit_cnt == DATA_LAST);
        tx_advance = sck_fall && (bit_cnt != DATA_LAST);
      end
      default: ;
    endcase
    addr_last = addr_shift && (bit_cnt == '0);
    word_done = data_shift && (bit_cnt == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_prev             <= 1'b0;
      warm                 <= '0;
      armed                <= 1'b0;
      bit_cnt              <= '0;
      address_out          <= '0;
      address_out_valid    <= 1'b0;
      inc_done             <= 1'b0;
      rx_shift             <= '0;
      write_data_out       <= '0;
      write_data_out_valid <= 1'b0;
      pend_dat             <= '0;
      pend_vld             <= 1'b0;
      tx_shift             <= '0;
      tx_empty             <= 1'b0;
      read_underrun_out    <= 1'b0;
    end else begin
      sck_prev <= sck_s;
      // Select only counts as released once the synchronizer holds real pin values.
      warm     <= {warm[0], 1'b1};
      armed    <= armed | (warm[1] & sel_s);

      if (start)                         bit_cnt <= ADDR_LAST;
      else if (addr_shift || data_shift) bit_cnt <= (bit_cnt == '0) ? DATA_LAST : bit_cnt - CNT_ONE;

      if (addr_shift)
        address_out <= (address_out << 1) | ADDR_WIDTH'(mosi_s);
      else if ((AUTO_INCREMENT != 0) && write_data_out_valid)
        address_out <= address_out + ADDR_ONE;
      inc_done          <= (AUTO_INCREMENT != 0) && write_data_out_valid;
      address_out_valid <= (addr_last && !sel_s) || inc_done;

      if (data_shift) rx_shift <= rx_next;
      if (word_done)  write_data_out <= rx_next;
      write_data_out_valid <= word_done;

      if (word_start) begin
        pend_vld <= 1'b0;
      end else if (read_data_in_valid) begin
        pend_dat <= read_data_in;
        pend_vld <= 1'b1;
      end

      if (state == ST_IDLE) begin
        tx_shift          <= '0;
        tx_empty          <= 1'b0;
        read_underrun_out <= 1'b0;
      end else begin
        if (word_start) begin
          if (read_data_in_valid) begin
            tx_shift <= read_data_in;
            tx_empty <= 1'b0;
          end else if (pend_vld) begin
            tx_shift <= pend_dat;
            tx_empty <= 1'b0;
          end else begin
            tx_shift <= '0;
            tx_empty <= 1'b1;
          end
        end else if (tx_advance) begin
          tx_shift <= tx_shift << 1;
        end
        // Flag only once an empty word is actually sampled, not on the trailing fall.
        if (data_shift && tx_empty) read_underrun_out <= 1'b1;
      end
    end
  end

endmodule
